prog_feeder: RTL and testbench

PROG_FEEDER -- requirements
Module: prog_feeder

---
 rtl/prog_feeder.sv | 168 ++++++++++++++++
 tb/tb_prog_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_feeder.sv
// Program feeder for a 9-bit processor: holds a 32-word program and issues
// one instruction word per processor time step zero, looping or halting at last_addr.
module prog_feeder #(
   localparam int unsigned AW    = 5,
   localparam int unsigned DW    = 9,
   localparam int unsigned DEPTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          loop,
   input  logic [AW-1:0] last_addr,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          done,
   output logic [DW-1:0] din,
   output logic          run,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          halted,
   output logic          err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ARM   = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_IMM   = 3'd3;
   localparam logic [2:0] S_EXEC  = 3'd4;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   localparam logic [1:0] MISS_LIMIT = 2'd2;

   logic [DW-1:0] mem [DEPTH];

   logic [2:0]    state, state_n;
   logic [1:0]    miss, miss_n;
   logic [AW-1:0] pc_n;
   logic [DW-1:0] din_n;
   logic          run_n, busy_n, halted_n, err_n;
   logic          mem_we_c;
   logic [AW-1:0] end_idx_c;
   logic          at_end_c;

   // Program memory: loadable only while idle, never cleared
   assign mem_we_c = ld_en && (state == S_IDLE);

   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem[ld_addr] <= ld_data;
      end
   end

   // Index of the last word of the instruction that is completing
   assign end_idx_c = (state == S_IMM) ? pc : AW'(pc - AW'(1));
   assign at_end_c  = (end_idx_c == last_addr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         miss   <= 2'd0;
         pc     <= '0;
         din    <= '0;
         run    <= 1'b0;
         busy   <= 1'b0;
         halted <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         miss   <= miss_n;
         pc     <= pc_n;
         din    <= din_n;
         run    <= run_n;
         busy   <= busy_n;
         halted <= halted_n;
         err    <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      miss_n   = 2'd0;
      pc_n     = pc;
      halted_n = halted;
      err_n    = err;
      din_n    = '0;
      run_n    = 1'b0;
      busy_n   = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_n  = S_ARM;
               pc_n     = '0;
               halted_n = 1'b0;
               err_n    = 1'b0;
            end
         end

         S_ARM: begin
            if (done) begin
               state_n = S_ISSUE;
            end
         end

         S_ISSUE: begin
            pc_n = AW'(pc + AW'(1));
            case (din[8:6])
               OP_MVI:               state_n = S_IMM;
               OP_MV, OP_ADD, OP_SUB: state_n = S_EXEC;
               default: begin
                  state_n = S_IDLE;
                  err_n   = 1'b1;
               end
            endcase
         end

         S_IMM, S_EXEC: begin
            if (done) begin
               // End-check: wrap, halt, or fall through to the next word
               if (state == S_IMM) begin
                  pc_n = AW'(pc + AW'(1));
               end
               if (at_end_c && loop) begin
                  state_n = S_ISSUE;
                  pc_n    = '0;
               end else if (at_end_c) begin
                  state_n  = S_IDLE;
                  halted_n = 1'b1;
               end else begin
                  state_n = S_ISSUE;
               end
            end else if ((state == S_IMM) || (miss == MISS_LIMIT)) begin
               state_n = S_IDLE;
               err_n   = 1'b1;
            end else begin
               miss_n = 2'(miss + 2'd1);
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Output words follow the state being entered
      case (state_n)
         S_ISSUE, S_IMM: begin
            din_n = mem[pc_n];
            run_n = 1'b1;
         end
         S_EXEC: begin
            din_n = din;
            run_n = 1'b1;
         end
         default: begin
            din_n = '0;
            run_n = 1'b0;
         end
      endcase
      busy_n = (state_n != S_IDLE);
   end

endmodule

// File: tb/tb_prog_feeder.sv
// Scoreboard bench for prog_feeder with a behavioural stub of the 9-bit processor
// that answers Done at the time step each opcode completes.
module tb_prog_feeder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, loop, ld_en, done;
   logic [4:0] last_addr, ld_addr;
   logic [8:0] ld_data;
   logic [8:0] din;
   logic       run, busy, halted, err;
   logic [4:0] pc;

   int checks = 0;
   int errors = 0;

   logic [13:0] exp_q[$];

   // Processor stub state
   logic       no_done = 1'b0;
   int         t = 0;
   logic [8:0] ir = '0;
   logic [8:0] r [8];

   prog_feeder dut (
      .clk(clk), .rst_n(rst_n), .start(start), .loop(loop), .last_addr(last_addr),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .done(done),
      .din(din), .run(run), .pc(pc), .busy(busy), .halted(halted), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h required %h", nm, got, want);
      end
   endtask

   task automatic push(input logic [8:0] d, input logic [4:0] p);
      exp_q.push_back({d, p});
   endtask

   // Monitor: every cycle with run high must match the next expected word/PC
   always @(negedge clk) begin
      logic [13:0] e;
      if (rst_n && run) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_run: got din=%h pc=%0d required no issue", din, pc);
         end else begin
            e = exp_q.pop_front();
            if ({din, pc} !== e) begin
               errors++;
               $display("FAIL issue: got din=%h pc=%0d required din=%h pc=%0d",
                        din, pc, e[13:5], e[4:0]);
            end
         end
      end
   end

   // Processor stub: ready in ARM; mv/mvi complete at T1, add/sub at T3
   always @(negedge clk) begin
      if (!busy) begin
         done = 1'b0;
         t    = 0;
      end else if (!run) begin
         done = 1'b1;
         t    = 0;
      end else if (t == 0) begin
         ir   = din;
         done = 1'b0;
         t    = 1;
      end else begin
         if (ir[8:6] == 3'b000 || ir[8:6] == 3'b001) done = (t == 1);
         else                                        done = (t == 3);
         if (no_done) done = 1'b0;
         if (done) begin
            case (ir[8:6])
               3'b000:  r[ir[5:3]] = r[ir[2:0]];
               3'b001:  r[ir[5:3]] = din;
               3'b010:  r[ir[5:3]] = r[ir[5:3]] + r[ir[2:0]];
               default: r[ir[5:3]] = r[ir[5:3]] - r[ir[2:0]];
            endcase
            t = 0;
         end else begin
            t++;
         end
      end
   end

   task automatic load(input logic [4:0] a, input logic [8:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
   endtask

   task automatic load_end();
      @(negedge clk);
      ld_en = 1'b0; start = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_idle(input int max, input string nm);
      int n = 0;
      do begin
         @(negedge clk); #1; n++;
      end while (busy && n < max);
      checks++;
      if (busy) begin
         errors++;
         $display("FAIL %s_timeout: got busy=1 required idle within %0d cycles", nm, max);
      end
   endtask

   task automatic push_p027();
      push(9'h040, 5'd0); push(9'h005, 5'd1); push(9'h080, 5'd2);
      for (int i = 0; i < 3; i++) push(9'h080, 5'd3);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; start = 1'b0; loop = 1'b0; ld_en = 1'b0;
      last_addr = '0; ld_addr = '0; ld_data = '0;
      for (int i = 0; i < 8; i++) r[i] = '0;
      #12;
      chk("rst_din", din, 9'h000);
      chk("rst_run", {8'd0, run}, 9'd0);
      chk("rst_pc", {4'd0, pc}, 9'd0);
      chk("rst_busy", {8'd0, busy}, 9'd0);
      chk("rst_halted", {8'd0, halted}, 9'd0);
      chk("rst_err", {8'd0, err}, 9'd0);
      @(negedge clk); rst_n = 1'b1;

      // mvi R0,#5 ; add R0,R0 ; halt. Start shares the edge with the last write.
      last_addr = 5'd2; loop = 1'b0;
      load(5'd0, 9'h040); load(5'd1, 9'h005);
      push_p027();
      load(5'd2, 9'h080); start = 1'b1;
      load_end();
      wait_idle(40, "p027");
      chk("p027_halted", {8'd0, halted}, 9'd1);
      chk("p027_err", {8'd0, err}, 9'd0);
      chk("p027_r0", r[0], 9'd10);
      chk("p027_q", 9'(exp_q.size()), 9'd0);

      // Looping: three full passes, Start pulsed mid-run must be ignored
      loop = 1'b1;
      for (int k = 0; k < 3; k++) push_p027();
      pulse_start();
      repeat (4) @(negedge clk);
      start = 1'b1; @(negedge clk); start = 1'b0;
      n = 0;
      do begin @(negedge clk); #1; n++; end while (exp_q.size() > 3 && n < 100);
      chk("loop_halted_running", {8'd0, halted}, 9'd0);
      chk("loop_busy_running", {8'd0, busy}, 9'd1);
      loop = 1'b0;
      wait_idle(20, "loop");
      chk("loop_halted", {8'd0, halted}, 9'd1);
      chk("loop_q", 9'(exp_q.size()), 9'd0);

      // Illegal opcode at address 0
      load(5'd0, 9'h100); load_end();
      push(9'h100, 5'd0);
      pulse_start();
      wait_idle(20, "illegal");
      chk("illegal_err", {8'd0, err}, 9'd1);
      chk("illegal_halted", {8'd0, halted}, 9'd0);
      chk("illegal_run", {8'd0, run}, 9'd0);
      chk("illegal_pc", {4'd0, pc}, 9'd1);
      chk("illegal_q", 9'(exp_q.size()), 9'd0);

      // Done withheld in EXEC: error after exactly three EXEC cycles
      load(5'd0, 9'h080); load_end();
      push(9'h080, 5'd0);
      for (int i = 0; i < 3; i++) push(9'h080, 5'd1);
      no_done = 1'b1;
      pulse_start();
      wait_idle(20, "stall");
      no_done = 1'b0;
      chk("stall_err", {8'd0, err}, 9'd1);
      chk("stall_q", 9'(exp_q.size()), 9'd0);

      // mvi at address 31 takes its immediate from address 0
      load(5'd0, 9'h0AB);
      for (int a = 1; a < 31; a++) load(5'(a), 9'h000);
      load(5'd31, 9'h040); load_end();
      last_addr = 5'd31;
      push(9'h0AB, 5'd0);
      for (int i = 0; i < 3; i++) push(9'h0AB, 5'd1);
      for (int a = 1; a < 31; a++) begin
         push(9'h000, 5'(a)); push(9'h000, 5'(a + 1));
      end
      push(9'h040, 5'd31); push(9'h0AB, 5'd0);
      pulse_start();
      n = 0;
      do begin @(negedge clk); #1; n++; end while (!(run && pc == 5'd31) && n < 200);
      chk("wrap_reach31", {4'd0, pc}, 9'd31);
      last_addr = 5'd0;
      wait_idle(20, "wrap");
      chk("wrap_halted", {8'd0, halted}, 9'd1);
      chk("wrap_err", {8'd0, err}, 9'd0);
      chk("wrap_pc", {4'd0, pc}, 9'd1);
      chk("wrap_q", 9'(exp_q.size()), 9'd0);

      // Reset during EXEC; loads while busy must not land
      last_addr = 5'd2;
      load(5'd0, 9'h040); load(5'd1, 9'h005); load(5'd2, 9'h080); load_end();
      push_p027();
      pulse_start();
      ld_en = 1'b1; ld_addr = 5'd0; ld_data = 9'h1FF;
      n = 0;
      do begin @(negedge clk); #1; n++; end while (!(run && pc == 5'd3) && n < 40);
      chk("rst_mid_exec", din, 9'h080);
      ld_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("rstm_din", din, 9'h000);
      chk("rstm_run", {8'd0, run}, 9'd0);
      chk("rstm_pc", {4'd0, pc}, 9'd0);
      chk("rstm_busy", {8'd0, busy}, 9'd0);
      chk("rstm_halted", {8'd0, halted}, 9'd0);
      chk("rstm_err", {8'd0, err}, 9'd0);
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1 chk("rstm_stay_idle", {8'd0, busy}, 9'd0);
      push_p027();
      pulse_start();
      wait_idle(40, "rerun");
      chk("rerun_halted", {8'd0, halted}, 9'd1);
      chk("rerun_r0", r[0], 9'd10);
      chk("rerun_q", 9'(exp_q.size()), 9'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
